// File: rtl/fc_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : fc_word_aligner
// Purpose  : Finds the 8-bit frame boundary of the fast-command bitstream
//            using the IDLE pattern and emits one aligned command per frame.
// Revision : 1.0 - initial release
// ============================================================================
module fc_word_aligner #(
    parameter logic [7:0] IDLE_WORD     = 8'hF0,
    parameter int         LOCK_THRESH   = 4,
    parameter int         UNLOCK_THRESH = 4
) (
    input  logic       clk1280,
    input  logic       rstn,
    input  logic [9:0] fc_para_InDelay,
    input  logic       realign,
    output logic [7:0] fc_word,
    output logic       fc_valid,
    output logic       aligned,
    output logic [2:0] phase,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TH   = 4'(LOCK_THRESH);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_THRESH);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] good_q, good_d;
    logic [3:0] bad_q, bad_d;
    logic [7:0] fc_word_q, fc_word_d;
    logic       fc_valid_q, fc_valid_d;
    logic       aligned_q, aligned_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [7:0] word0;
    logic       boundary;
    logic       word_ok;
    logic       hit;
    logic [2:0] hit_cnt;

    assign word0    = fc_para_InDelay[7:0];
    assign boundary = (cnt_q == 3'd0);
    assign word_ok  = ($countones(word0) == 4);

    // Lowest offset wins; loading k+1 makes the next offset-0 word land on cnt==0.
    always_comb begin
        hit     = 1'b0;
        hit_cnt = 3'd0;
        if (fc_para_InDelay[7:0] == IDLE_WORD) begin
            hit     = 1'b1;
            hit_cnt = 3'd1;
        end else if (fc_para_InDelay[8:1] == IDLE_WORD) begin
            hit     = 1'b1;
            hit_cnt = 3'd2;
        end else if (fc_para_InDelay[9:2] == IDLE_WORD) begin
            hit     = 1'b1;
            hit_cnt = 3'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 3'd1;
        good_d     = good_q;
        bad_d      = bad_q;
        fc_word_d  = fc_word_q;
        fc_valid_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (realign) begin
            state_d = ST_SEARCH;
            good_d  = 4'd0;
            bad_d   = 4'd0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (hit) begin
                        cnt_d   = hit_cnt;
                        good_d  = 4'd1;
                        state_d = (LOCK_TH <= 4'd1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (boundary) begin
                        if (word0 == IDLE_WORD) begin
                            if (good_q + 4'd1 >= LOCK_TH) begin
                                state_d = ST_LOCKED;
                                good_d  = 4'd0;
                            end else begin
                                good_d = good_q + 4'd1;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            good_d  = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        // The word is forwarded even when it is the one that breaks lock.
                        fc_word_d  = word0;
                        fc_valid_d = 1'b1;
                        if (word_ok) begin
                            bad_d = 4'd0;
                        end else begin
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                            if (bad_q + 4'd1 >= UNLOCK_TH) begin
                                state_d = ST_SEARCH;
                                bad_d   = 4'd0;
                            end else begin
                                bad_d = bad_q + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk1280 or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_SEARCH;
            cnt_q      <= 3'd0;
            good_q     <= 4'd0;
            bad_q      <= 4'd0;
            fc_word_q  <= 8'h00;
            fc_valid_q <= 1'b0;
            aligned_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            fc_word_q  <= fc_word_d;
            fc_valid_q <= fc_valid_d;
            aligned_q  <= aligned_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign fc_word  = fc_word_q;
    assign fc_valid = fc_valid_q;
    assign aligned  = aligned_q;
    assign phase    = cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_word_aligner
// Purpose  : Directed bitstream bench for fc_word_aligner with a strobe queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_word_aligner;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] win;
    logic       realign;
    logic [7:0] fc_word;
    logic       fc_valid;
    logic       aligned;
    logic [2:0] phase;
    logic [7:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_strobe = -100;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fc_word_aligner dut (
        .clk1280         (clk),
        .rstn            (rstn),
        .fc_para_InDelay (win),
        .realign         (realign),
        .fc_word         (fc_word),
        .fc_valid        (fc_valid),
        .aligned         (aligned),
        .phase           (phase),
        .err_cnt         (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit per cycle; every strobe is matched against the queue head.
    task automatic tick(input logic b, input logic rl);
        logic [7:0] e;
        win     = {win[8:0], b};
        realign = rl;
        @(posedge clk);
        #1;
        cyc++;
        if (fc_valid === 1'b1) begin
            check("strobe_gap", 32'(cyc - last_strobe >= 8), 32'd1);
            last_strobe = cyc;
            check("strobe_phase", 32'(phase), 32'd1);
            check("queue_depth_at_strobe", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fc_word", 32'(fc_word), 32'(e));
            end
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic expect_out, input logic [7:0] rlmask);
        for (int i = 7; i >= 0; i--) begin
            if (expect_out && i == 0) exp_q.push_back(w);
            tick(w[i], rlmask[i]);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        win     = 10'd0;
        realign = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rst_fc_word", 32'(fc_word), 32'h00);
        check("rst_fc_valid", 32'(fc_valid), 32'd0);
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rstn = 1'b1;

        // Continuous IDLE from offset 0: lock lands on the 4th IDLE boundary.
        for (int n = 0; n < 3; n++) send_word(8'hF0, 1'b0, 8'h00);
        check("idle0_not_yet_aligned", 32'(aligned), 32'd0);
        send_word(8'hF0, 1'b0, 8'h00);
        check("idle0_aligned", 32'(aligned), 32'd1);
        for (int n = 0; n < 3; n++) send_word(8'hF0, 1'b1, 8'h00);
        check("idle0_err_cnt", 32'(err_cnt), 32'd0);

        // Valid commands pass through without errors.
        send_word(8'h96, 1'b1, 8'h00);
        send_word(8'h5A, 1'b1, 8'h00);
        send_word(8'hF0, 1'b1, 8'h00);
        check("cmd_err_cnt", 32'(err_cnt), 32'd0);
        check("cmd_aligned", 32'(aligned), 32'd1);

        // Four invalid words drop lock; the 4th is still forwarded.
        for (int n = 0; n < 3; n++) send_word(8'hFF, 1'b1, 8'h00);
        check("ff3_aligned", 32'(aligned), 32'd1);
        send_word(8'hFF, 1'b1, 8'h00);
        check("ff4_aligned", 32'(aligned), 32'd0);
        check("ff4_err_cnt", 32'(err_cnt), 32'd4);
        for (int n = 0; n < 4; n++) send_word(8'hF0, 1'b0, 8'h00);
        check("relock_aligned", 32'(aligned), 32'd1);
        send_word(8'hF0, 1'b1, 8'h00);

        // Three invalid words then a valid one clear the bad run.
        for (int n = 0; n < 3; n++) send_word(8'h00, 1'b1, 8'h00);
        send_word(8'hF0, 1'b1, 8'h00);
        for (int n = 0; n < 3; n++) send_word(8'h00, 1'b1, 8'h00);
        check("bad_run_aligned", 32'(aligned), 32'd1);
        check("bad_run_err_cnt", 32'(err_cnt), 32'd10);
        send_word(8'hF0, 1'b1, 8'h00);

        // realign on a boundary cycle: no strobe, lock dropped, err_cnt kept.
        send_word(8'hF0, 1'b0, 8'h01);
        check("realign_fc_valid", 32'(fc_valid), 32'd0);
        check("realign_aligned", 32'(aligned), 32'd0);
        check("realign_err_cnt", 32'(err_cnt), 32'd10);
        // Hold realign one more cycle so the first match is at offset 2.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("offset2_phase", 32'(phase), 32'd3);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) tick(1'b0, 1'b0);
        send_word(8'hF0, 1'b0, 8'h00);
        check("offset2_not_yet_aligned", 32'(aligned), 32'd0);
        send_word(8'hF0, 1'b0, 8'h00);
        check("offset2_aligned", 32'(aligned), 32'd1);
        send_word(8'hF0, 1'b1, 8'h00);
        send_word(8'hF0, 1'b1, 8'h00);

        // Asynchronous reset in the middle of a frame.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_fc_word", 32'(fc_word), 32'h00);
        check("async_fc_valid", 32'(fc_valid), 32'd0);
        check("async_aligned", 32'(aligned), 32'd0);
        check("async_phase", 32'(phase), 32'd0);
        check("async_err_cnt", 32'(err_cnt), 32'd0);
        tick(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) tick(1'b0, 1'b0);
        rstn = 1'b1;
        // The completed IDLE now sits at offset 1 on the first post-reset edge.
        send_word(8'hF0, 1'b0, 8'h00);
        send_word(8'hF0, 1'b0, 8'h00);
        check("postrst_not_yet_aligned", 32'(aligned), 32'd0);
        send_word(8'hF0, 1'b0, 8'h00);
        check("postrst_aligned", 32'(aligned), 32'd1);
        send_word(8'hF0, 1'b1, 8'h00);
        check("postrst_err_cnt", 32'(err_cnt), 32'd0);

        check("pending_strobes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
